// File: rtl/mux_demux_pkg.sv
// Definitions shared by the 4:1 round-robin mux and the 1:4 demux, so both ends
// use the same channel-index encoding.
package mux_demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // The round-robin pointer moves to the channel after the winner and wraps 3 -> 0.
  function automatic ch_idx_t next_idx(input ch_idx_t idx);
    return idx + ch_idx_t'(1);
  endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter. The search starts at ptr and wraps;
// grant is one-hot and is asserted only when en is high.
module rr_arbiter4
  import mux_demux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output ch_idx_t           grant_idx
);

  logic    found;
  ch_idx_t cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ptr + ch_idx_t'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mux4_1_rr.sv
// 4:1 round-robin mux with one registered output stage. Each output beat is
// tagged with its source channel index, which drives the far-end demux select.
module mux4_1_rr
  import mux_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output ch_idx_t                 out_sel,
  input  logic                    out_ready
);

  // Handshake rules: a beat moves on a channel when valid and ready are both high
  // at the rising edge. in_ready is high only for the channel holding the grant,
  // and only while the output register can accept data, meaning it is empty or
  // is being drained in the same cycle. While out_valid=1 and out_ready=0 the
  // output beat is held unchanged.

  logic              loadable;
  logic [NUM_CH-1:0] grant;
  ch_idx_t           grant_idx;
  ch_idx_t           rr_ptr;
  logic              take;

  assign loadable = !out_valid || out_ready;

  rr_arbiter4 u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .en        (loadable),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Hold in_ready low while reset is asserted so no source sees a phantom accept.
  assign in_ready = grant & {NUM_CH{rst_n}};
  assign take     = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (loadable) begin
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
        out_sel   <= grant_idx;
        rr_ptr    <= next_idx(grant_idx);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux4_1_rr.sv
// Directed self-checking bench for mux4_1_rr. Each scenario is a task with
// hand-computed expectations.
module tb_mux4_1_rr;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  int checks;
  int failures;

  mux4_1_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Inputs change at the falling edge; registered outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++;
    if (out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
    in_valid = 4'b0000;
    rst_n    = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++;
    if (out_data !== 8'hA5) begin failures++; $display("FAIL single_out_data got=%h exp=a5", out_data); end
    checks++;
    if (out_sel !== 2'd2) begin failures++; $display("FAIL single_out_sel got=%0d exp=2", out_sel); end
    @(negedge clk);
    in_valid = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_sel;
    logic [3:0] exp_ready;
    logic [7:0] exp_data;
    do_reset();
    in_data   = 32'h13121110;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_sel   = 2'(i % 4);
      exp_ready = 4'b0001 << exp_sel;
      exp_data  = 8'h10 + 8'(exp_sel);
      #1;
      checks++;
      if (in_ready !== exp_ready) begin failures++; $display("FAIL fair_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_data) begin
        failures++;
        $display("FAIL fair_out[%0d] got=v%b s%0d d%h exp=v1 s%0d d%h", i, out_valid, out_sel, out_data, exp_sel, exp_data);
      end
      @(negedge clk);
    end
  endtask

  // Continues from fairness: beat from ch1 held, rr_ptr now points at ch2.
  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=v%b s%0d d%h exp=v1 s1 d11", i, out_valid, out_sel, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h12) begin
      failures++;
      $display("FAIL bp_release_out got=v%b s%0d d%h exp=v1 s2 d12", out_valid, out_sel, out_data);
    end
    @(negedge clk);
  endtask

  // Continues from backpressure: rr_ptr points at ch3.
  task automatic test_wrap();
    in_valid = 4'b1000;
    step();
    checks++;
    if (out_sel !== 2'd3 || out_data !== 8'h13) begin failures++; $display("FAIL wrap_ch3 got=s%0d d%h exp=s3 d13", out_sel, out_data); end
    in_valid = 4'b1001;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL wrap_in_ready got=%b exp=0001", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (out_sel !== 2'd0 || out_data !== 8'h10) begin failures++; $display("FAIL wrap_ch0 got=s%0d d%h exp=s0 d10", out_sel, out_data); end
    @(negedge clk);
  endtask

  // A held beat is discarded by an asynchronous reset and is not replayed.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL midreset_async got=v%b s%0d d%h exp=v0 s0 d00", out_valid, out_sel, out_data);
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_replay got=%b exp=0", out_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
